data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_pkg.sv | 18 +
 rtl/sp_ram.sv | 38 +++
 rtl/data_memory_ctrl.sv | 127 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared constants and types for the boot-loadable data memory controller.
package data_memory_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DEPTH_DEF  = 8192;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Index width of the storage array; a one-word memory still needs one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM: synchronous write, registered read, array never reset.
module sp_ram
    import data_memory_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned IDX_W  = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Output register holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: loads a boot stream into sp_ram, then serves
// single-cycle-issue reads/writes with range checking.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter bit          BOOT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              ready,
    output logic              err,
    input  logic              boot_valid,
    input  logic [DATA_W-1:0] boot_data,
    input  logic              boot_last,
    output logic              boot_done
);

    localparam int unsigned IDX_W      = idx_width(DEPTH);
    localparam state_e      RST_STATE  = BOOT_EN ? ST_BOOT : ST_RUN;
    localparam logic        RUN_AT_RST = (BOOT_EN == 1'b0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              boot_done_q, boot_done_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    logic              in_range_c;
    logic              ram_we_c;
    logic              ram_re_c;
    logic [IDX_W-1:0]  ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;

    // Widened compare so DEPTH == 2^ADDR_W does not wrap to zero.
    assign in_range_c = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            ptr_q       <= '0;
            ready_q     <= RUN_AT_RST;
            boot_done_q <= RUN_AT_RST;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            boot_done_q <= boot_done_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
        end
    end

    // Port arbitration: the boot stream owns the RAM in BOOT, the request port in RUN.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ready_d     = ready_q;
        boot_done_d = boot_done_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;
        ram_addr_c  = addr[IDX_W-1:0];
        ram_wdata_c = wdata;

        case (state_q)
            ST_BOOT: begin
                if (boot_valid) begin
                    ram_we_c    = 1'b1;
                    ram_addr_c  = ptr_q;
                    ram_wdata_c = boot_data;
                    ptr_d       = ptr_q + IDX_W'(1);
                    if (boot_last || (ptr_q == LAST_IDX)) begin
                        state_d     = ST_RUN;
                        ready_d     = 1'b1;
                        boot_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (req) begin
                    if (!in_range_c) begin
                        err_d = 1'b1;
                    end else if (we) begin
                        ram_we_c = 1'b1;
                    end else begin
                        ram_re_c = 1'b1;
                        rvalid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_sp_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (ram_addr_c),
        .wdata_i (ram_wdata_c),
        .rdata_o (rdata)
    );

    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign ready     = ready_q;
    assign boot_done = boot_done_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: one booting instance (DEPTH 8192) and one direct-run
// instance (DEPTH 1000) sharing clock, reset and boot stream.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_valid, boot_last;
    logic [7:0]  boot_data;

    logic        req_a, we_a, rvalid_a, ready_a, err_a, boot_done_a;
    logic [12:0] addr_a;
    logic [7:0]  wdata_a, rdata_a;

    logic        req_b, we_b, rvalid_b, ready_b, err_b, boot_done_b;
    logic [12:0] addr_b;
    logic [7:0]  wdata_b, rdata_b;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_ctrl #(.DATA_W(8), .ADDR_W(13), .DEPTH(8192), .BOOT_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .rvalid(rvalid_a), .ready(ready_a), .err(err_a),
        .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
        .boot_done(boot_done_a)
    );

    data_memory_ctrl #(.DATA_W(8), .ADDR_W(13), .DEPTH(1000), .BOOT_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .rvalid(rvalid_b), .ready(ready_b), .err(err_b),
        .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
        .boot_done(boot_done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Pops one expected response per output pulse and checks kind, data and latency.
    task automatic mon(input int inst, input logic rv, input logic er, input logic [7:0] rd);
        exp_t e;
        int   depth;
        if (!(rv || er)) return;
        depth = (inst == 0) ? qa.size() : qb.size();
        if (depth == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_%0d: rvalid=%0b err=%0b at cyc %0d, expected no pulse",
                     inst, rv, er, cyc);
            return;
        end
        if (inst == 0) e = qa.pop_front();
        else           e = qb.pop_front();
        chk($sformatf("out_err_%0d", inst),  32'(er), 32'(e.is_err));
        chk($sformatf("out_rv_%0d", inst),   32'(rv), 32'(!e.is_err));
        chk($sformatf("out_data_%0d", inst), 32'(rd), 32'(e.data));
        chk($sformatf("out_cyc_%0d", inst),  32'(cyc), 32'(e.cyc));
    endtask

    always @(negedge clk) begin
        mon(0, rvalid_a, err_a, rdata_a);
        mon(1, rvalid_b, err_b, rdata_b);
    end

    // kind: 0 = no response, 1 = read data, 2 = err pulse (data = held rdata).
    task automatic op(input int inst, input bit w, input int a, input logic [7:0] d,
                      input int kind, input logic [7:0] exp);
        exp_t e;
        e.is_err = (kind == 2);
        e.data   = exp;
        e.cyc    = cyc + 1;
        if (kind != 0) begin
            if (inst == 0) qa.push_back(e);
            else           qb.push_back(e);
        end
        if (inst == 0) begin
            req_a = 1'b1; we_a = w; addr_a = 13'(a); wdata_a = d;
        end else begin
            req_b = 1'b1; we_b = w; addr_b = 13'(a); wdata_b = d;
        end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic boot_word(input logic [7:0] d, input bit last);
        boot_valid = 1'b1;
        boot_data  = d;
        boot_last  = last;
        @(negedge clk);
        boot_valid = 1'b0;
        boot_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        boot_valid = 1'b0; boot_last = 1'b0; boot_data = '0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

        @(negedge clk);
        chk("rst_rdata_a", 32'(rdata_a), 32'h0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'h0);
        chk("rst_err_a", 32'(err_a), 32'h0);
        chk("rst_ready_a", 32'(ready_a), 32'h0);
        chk("rst_boot_done_a", 32'(boot_done_a), 32'h0);
        chk("rst_ready_b", 32'(ready_b), 32'h1);
        chk("rst_boot_done_b", 32'(boot_done_b), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_ready_b", 32'(ready_b), 32'h1);
        chk("boot_ready_a", 32'(ready_a), 32'h0);

        boot_word(8'h01, 1'b0);
        boot_word(8'h02, 1'b0);
        boot_word(8'h03, 1'b0);
        chk("boot_mid_done_a", 32'(boot_done_a), 32'h0);
        boot_word(8'h04, 1'b1);
        chk("boot_end_ready_a", 32'(ready_a), 32'h1);
        chk("boot_end_done_a", 32'(boot_done_a), 32'h1);

        for (int i = 0; i < 4; i++) op(0, 1'b0, i, 8'h00, 1, 8'(i + 1));
        op(0, 1'b1, 16, 8'h5A, 0, 8'h00);
        op(0, 1'b1, 1, 8'h07, 0, 8'h00);
        op(0, 1'b0, 1, 8'h00, 1, 8'h07);
        for (int i = 0; i < 4; i++) op(0, 1'b1, 1000 + i, 8'hA0 + 8'(i), 0, 8'h00);
        for (int i = 0; i < 4; i++) op(0, 1'b0, 1000 + i, 8'h00, 1, 8'hA0 + 8'(i));
        @(negedge clk);
        chk("hold_rdata_a", 32'(rdata_a), 32'hA3);
        chk("idle_rvalid_a", 32'(rvalid_a), 32'h0);

        op(1, 1'b1, 0, 8'h3C, 0, 8'h00);
        op(1, 1'b0, 0, 8'h00, 1, 8'h3C);
        op(1, 1'b0, 1000, 8'h00, 2, 8'h3C);
        op(1, 1'b1, 1000, 8'hEE, 2, 8'h3C);
        op(1, 1'b0, 0, 8'h00, 1, 8'h3C);
        op(1, 1'b1, 999, 8'h99, 0, 8'h00);
        op(1, 1'b0, 999, 8'h00, 1, 8'h99);
        op(1, 1'b0, 8191, 8'h00, 2, 8'h99);
        @(negedge clk);
        chk("hold_rdata_b", 32'(rdata_b), 32'h99);

        // Asynchronous reset mid-cycle clears outputs before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rdata_a", 32'(rdata_a), 32'h0);
        chk("async_ready_a", 32'(ready_a), 32'h0);
        chk("async_done_a", 32'(boot_done_a), 32'h0);
        chk("async_rdata_b", 32'(rdata_b), 32'h0);
        chk("async_ready_b", 32'(ready_b), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 1'b1, 16, 8'hAA, 0, 8'h00);
        op(0, 1'b0, 16, 8'h00, 0, 8'h00);
        boot_word(8'h11, 1'b0);
        boot_word(8'h22, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midboot_done_a", 32'(boot_done_a), 32'h0);
        chk("midboot_rvalid_a", 32'(rvalid_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        boot_word(8'h01, 1'b0);
        boot_word(8'h02, 1'b0);
        boot_word(8'h03, 1'b0);
        boot_word(8'h04, 1'b1);
        chk("reboot_ready_a", 32'(ready_a), 32'h1);
        for (int i = 0; i < 4; i++) op(0, 1'b0, i, 8'h00, 1, 8'(i + 1));
        op(0, 1'b0, 16, 8'h00, 1, 8'h5A);

        // Full-depth boot without boot_last must end on the final word.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            boot_word(8'(i), 1'b0);
            if (i == 8190) chk("full_boot_pre_done", 32'(boot_done_a), 32'h0);
        end
        chk("full_boot_done", 32'(boot_done_a), 32'h1);
        chk("full_boot_ready", 32'(ready_a), 32'h1);
        boot_word(8'hEE, 1'b1);
        op(0, 1'b0, 0, 8'h00, 1, 8'h00);
        op(0, 1'b0, 8191, 8'h00, 1, 8'hFF);
        op(0, 1'b0, 5, 8'h00, 1, 8'h05);
        op(0, 1'b0, 1000, 8'h00, 1, 8'hE8);
        @(negedge clk);
        @(negedge clk);

        chk("pending_a", 32'(qa.size()), 32'h0);
        chk("pending_b", 32'(qb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
